spi_iomem_bridge: RTL and testbench

SPI target that turns transactions from an external MCU into cycles on the SoC `iomem` bus, as the alternative initiator to the on-chip CPU when firmware runs off-chip. It receives command, address and data frames on a mode-0 SPI link. It drives one 32-bit `iomem` read or write per frame and returns read data on MISO. All logic runs in the system clock domain; SPI pins are oversampled.

---
 rtl/spi_iomem_bridge_pkg.sv | 43 ++++
 rtl/spi_pin_sync.sv | 51 +++++
 rtl/spi_iomem_bridge.sv | 254 +++++++++++++++++++++++++
 tb/tb_spi_iomem_bridge.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_iomem_bridge_pkg.sv
// Shared definitions for the SPI-to-iomem bridge: command and status codes,
// FSM state encoding, field lengths and small helper functions.
package spi_iomem_bridge_pkg;

   localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
   localparam logic [7:0] SPI_CMD_READ  = 8'h03;

   localparam logic [7:0] SPI_ST_OK     = 8'h01;
   localparam logic [7:0] SPI_ST_BUSY   = 8'h00;

   localparam logic [5:0] BITS_BYTE_LAST = 6'd7;
   localparam logic [5:0] BITS_WORD_LAST = 6'd31;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_CMD    = 4'd1,
      ST_ADDR   = 4'd2,
      ST_WDATA  = 4'd3,
      ST_WBUS   = 4'd4,
      ST_RBUS   = 4'd5,
      ST_STATUS = 4'd6,
      ST_RDATA  = 4'd7,
      ST_IGNORE = 4'd8
   } state_e;

   // Index of the last bit of the field received/sent in a given state.
   function automatic logic [5:0] field_last(input state_e st);
      case (st)
         ST_CMD, ST_STATUS: return BITS_BYTE_LAST;
         default:           return BITS_WORD_LAST;
      endcase
   endfunction

   // Status byte returned ahead of the read data.
   function automatic logic [7:0] status_code(input logic ok);
      if (ok) begin
         return SPI_ST_OK;
      end else begin
         return SPI_ST_BUSY;
      end
   endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronises the SPI pins into the system clock domain and produces
// single-cycle pulses for SCK rising/falling and CS falling/rising edges.
module spi_pin_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic resetn_i,
   input  logic sck_i,
   input  logic cs_n_i,
   input  logic mosi_i,
   output logic mosi_o,
   output logic sck_rise_o,
   output logic sck_fall_o,
   output logic cs_fall_o,
   output logic cs_rise_o
);

   logic [SYNC_STAGES-1:0] sck_sync_q;
   logic [SYNC_STAGES-1:0] cs_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic                   sck_prev_q;
   logic                   cs_prev_q;
   logic                   sck_s;
   logic                   cs_s;

   // Synchroniser chains plus one edge-detect flop; CS idles high so no false edge leaves reset.
   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         sck_sync_q  <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sck_prev_q  <= 1'b0;
         cs_prev_q   <= 1'b1;
      end else begin
         sck_sync_q  <= (sck_sync_q << 1) | SYNC_STAGES'(sck_i);
         cs_sync_q   <= (cs_sync_q << 1) | SYNC_STAGES'(cs_n_i);
         mosi_sync_q <= (mosi_sync_q << 1) | SYNC_STAGES'(mosi_i);
         sck_prev_q  <= sck_s;
         cs_prev_q   <= cs_s;
      end
   end

   assign sck_s      = sck_sync_q[SYNC_STAGES-1];
   assign cs_s       = cs_sync_q[SYNC_STAGES-1];
   assign mosi_o     = mosi_sync_q[SYNC_STAGES-1];
   assign sck_rise_o = sck_s & ~sck_prev_q;
   assign sck_fall_o = ~sck_s & sck_prev_q;
   assign cs_fall_o  = ~cs_s & cs_prev_q;
   assign cs_rise_o  = cs_s & ~cs_prev_q;

endmodule

// File: rtl/spi_iomem_bridge.sv
// SPI mode-0 target that converts write/read frames from an external MCU
// into single 32-bit iomem bus cycles and returns read data on MISO.
module spi_iomem_bridge
   import spi_iomem_bridge_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        spi_sck,
   input  logic        spi_cs_n,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic        iomem_valid,
   input  logic        iomem_ready,
   output logic [3:0]  iomem_wstrb,
   output logic [31:0] iomem_addr,
   output logic [31:0] iomem_wdata,
   input  logic [31:0] iomem_rdata
);

   logic mosi_s, sck_rise_s, sck_fall_s, cs_fall_s, cs_rise_s;

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
      .clk_i      (clk),
      .resetn_i   (resetn),
      .sck_i      (spi_sck),
      .cs_n_i     (spi_cs_n),
      .mosi_i     (spi_mosi),
      .mosi_o     (mosi_s),
      .sck_rise_o (sck_rise_s),
      .sck_fall_o (sck_fall_s),
      .cs_fall_o  (cs_fall_s),
      .cs_rise_o  (cs_rise_s)
   );

   state_e      state_q, state_d;
   logic [5:0]  bit_cnt_q, bit_cnt_d;
   logic [31:0] shift_q, shift_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rd_data_q, rd_data_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic        valid_q, valid_d;
   logic        is_read_q, is_read_d;
   logic        rd_done_q, rd_done_d;
   logic        cs_pend_q, cs_pend_d;
   logic        tx_loaded_q, tx_loaded_d;
   logic        miso_q, miso_d;
   logic [38:0] tx_q, tx_d;

   logic [31:0] shifted_s;
   logic [31:0] rd_word_s;
   logic [7:0]  status_s;
   logic        field_end_s, bus_done_s, cs_pend_s, leave_s, rd_ok_s, counting_s;

   assign shifted_s   = {shift_q[30:0], mosi_s};
   assign field_end_s = sck_rise_s && (bit_cnt_q == field_last(state_q));
   assign counting_s  = state_q inside {ST_CMD, ST_ADDR, ST_WDATA, ST_STATUS, ST_RDATA};
   assign bus_done_s  = valid_q && iomem_ready;
   // A CS rise is remembered until any outstanding bus cycle has completed.
   assign cs_pend_s   = cs_rise_s || cs_pend_q;
   assign leave_s     = cs_pend_s && (state_q != ST_IDLE) && (!valid_q || iomem_ready);
   // Read data counts as ready if already captured or being captured this cycle.
   assign rd_ok_s     = rd_done_q || (bus_done_s && (wstrb_q == 4'h0));
   assign status_s    = status_code(rd_ok_s);
   assign rd_word_s   = !rd_ok_s ? 32'hFFFF_FFFF : (rd_done_q ? rd_data_q : iomem_rdata);

   // State register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: frame sequencing and CS-driven return to IDLE.
   always_comb begin
      state_d = state_q;
      if (leave_s) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cs_fall_s) state_d = ST_CMD;
               else           state_d = ST_IDLE;
            end
            ST_CMD: begin
               if (field_end_s) begin
                  if ((shifted_s[7:0] == SPI_CMD_WRITE) || (shifted_s[7:0] == SPI_CMD_READ)) state_d = ST_ADDR;
                  else                                                                     state_d = ST_IGNORE;
               end else begin
                  state_d = ST_CMD;
               end
            end
            ST_ADDR: begin
               if (field_end_s) state_d = is_read_q ? ST_RBUS : ST_WDATA;
               else             state_d = ST_ADDR;
            end
            ST_WDATA: begin
               if (field_end_s) state_d = ST_WBUS;
               else             state_d = ST_WDATA;
            end
            ST_WBUS: begin
               if (bus_done_s) state_d = ST_IGNORE;
               else            state_d = ST_WBUS;
            end
            ST_RBUS:   state_d = ST_STATUS;
            ST_STATUS: begin
               if (field_end_s) state_d = ST_RDATA;
               else             state_d = ST_STATUS;
            end
            ST_RDATA: begin
               if (field_end_s) state_d = ST_IGNORE;
               else             state_d = ST_RDATA;
            end
            ST_IGNORE: state_d = ST_IGNORE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // Output/datapath logic: bit shifting, bus launch/completion and MISO shifting.
   always_comb begin
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rd_data_d   = rd_data_q;
      wstrb_d     = wstrb_q;
      valid_d     = valid_q;
      is_read_d   = is_read_q;
      rd_done_d   = rd_done_q;
      tx_d        = tx_q;
      tx_loaded_d = tx_loaded_q;
      miso_d      = miso_q;
      cs_pend_d   = cs_pend_s && !leave_s && (state_q != ST_IDLE);

      // Bus completion: drop valid and capture read data.
      if (bus_done_s) begin
         valid_d = 1'b0;
         if (wstrb_q == 4'h0) begin
            rd_data_d = iomem_rdata;
            rd_done_d = 1'b1;
         end else begin
            rd_done_d = rd_done_q;
         end
      end else begin
         valid_d = valid_q;
      end

      // Frame start clears per-frame context; otherwise shift MOSI into the field.
      if ((state_q == ST_IDLE) && cs_fall_s) begin
         bit_cnt_d   = 6'd0;
         shift_d     = 32'h0;
         is_read_d   = 1'b0;
         rd_done_d   = 1'b0;
         tx_d        = 39'h0;
         tx_loaded_d = 1'b0;
      end else if (counting_s && sck_rise_s) begin
         shift_d   = shifted_s;
         bit_cnt_d = field_end_s ? 6'd0 : (bit_cnt_q + 6'd1);
      end else begin
         shift_d = shift_q;
      end

      // Field completion: latch command, address, data and launch the bus cycle.
      if (field_end_s && !leave_s) begin
         case (state_q)
            ST_CMD: is_read_d = (shifted_s[7:0] == SPI_CMD_READ);
            ST_ADDR: begin
               addr_d = shifted_s;
               if (is_read_q) begin
                  valid_d = 1'b1;
                  wstrb_d = 4'h0;
               end else begin
                  valid_d = valid_q;
               end
            end
            ST_WDATA: begin
               wdata_d = shifted_s;
               valid_d = 1'b1;
               wstrb_d = 4'hF;
            end
            default: is_read_d = is_read_q;
         endcase
      end else begin
         is_read_d = is_read_d;
      end

      // MISO: fixed levels outside the read phases, shifted on SCK falls inside.
      case (state_q)
         ST_IDLE, ST_IGNORE:                miso_d = 1'b1;
         ST_CMD, ST_ADDR, ST_WDATA, ST_WBUS: miso_d = 1'b0;
         ST_RBUS:                           miso_d = miso_q;
         ST_STATUS, ST_RDATA: begin
            if (sck_fall_s) begin
               if (!tx_loaded_q) begin
                  miso_d      = status_s[7];
                  tx_d        = {status_s[6:0], rd_word_s};
                  tx_loaded_d = 1'b1;
               end else begin
                  miso_d = tx_q[38];
                  tx_d   = {tx_q[37:0], 1'b1};
               end
            end else begin
               miso_d = miso_q;
            end
         end
         default: miso_d = 1'b1;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         bit_cnt_q   <= 6'd0;
         shift_q     <= 32'h0;
         addr_q      <= 32'h0;
         wdata_q     <= 32'h0;
         rd_data_q   <= 32'h0;
         wstrb_q     <= 4'h0;
         valid_q     <= 1'b0;
         is_read_q   <= 1'b0;
         rd_done_q   <= 1'b0;
         cs_pend_q   <= 1'b0;
         tx_q        <= 39'h0;
         tx_loaded_q <= 1'b0;
         miso_q      <= 1'b1;
      end else begin
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rd_data_q   <= rd_data_d;
         wstrb_q     <= wstrb_d;
         valid_q     <= valid_d;
         is_read_q   <= is_read_d;
         rd_done_q   <= rd_done_d;
         cs_pend_q   <= cs_pend_d;
         tx_q        <= tx_d;
         tx_loaded_q <= tx_loaded_d;
         miso_q      <= miso_d;
      end
   end

   assign spi_miso    = miso_q;
   assign iomem_valid = valid_q;
   assign iomem_wstrb = wstrb_q;
   assign iomem_addr  = addr_q;
   assign iomem_wdata = wdata_q;

endmodule

// File: tb/tb_spi_iomem_bridge.sv
// Scoreboard testbench for spi_iomem_bridge: stimulus pushes expected bus
// transactions and MISO bytes; independent monitors pop and compare.
module tb_spi_iomem_bridge;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        spi_sck = 1'b0;
   logic        spi_cs_n = 1'b1;
   logic        spi_mosi = 1'b0;
   logic        spi_miso;
   logic        iomem_valid;
   logic        iomem_ready = 1'b0;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata = 32'h0;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          cycles;
   } bus_exp_t;

   bus_exp_t    bus_q[$];
   logic [7:0]  miso_q[$];

   int          bus_lat    = 0;
   bit          ready_hold = 1'b0;
   logic [31:0] rd_value   = 32'h0;

   always #5 clk = ~clk;

   spi_iomem_bridge #(.SYNC_STAGES(2)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .spi_sck     (spi_sck),
      .spi_cs_n    (spi_cs_n),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .iomem_valid (iomem_valid),
      .iomem_ready (iomem_ready),
      .iomem_wstrb (iomem_wstrb),
      .iomem_addr  (iomem_addr),
      .iomem_wdata (iomem_wdata),
      .iomem_rdata (iomem_rdata)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h, required %h", name, act, exp);
      end
   endtask

   // Bus target: ready after bus_lat cycles of valid (or held high), one cycle wide.
   initial begin : responder
      int cnt;
      cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (ready_hold) begin
            iomem_ready = 1'b1;
         end else if (iomem_ready) begin
            iomem_ready = 1'b0;
            cnt = 0;
         end else if (iomem_valid) begin
            cnt++;
            if (cnt >= bus_lat) begin
               iomem_ready = 1'b1;
               iomem_rdata = rd_value;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Bus monitor: one scoreboard pop per completed handshake.
   initial begin : bus_mon
      bit          in_txn, prev_done, stable;
      int          cyc;
      logic [31:0] a0, w0;
      logic [3:0]  s0;
      bus_exp_t    e;
      in_txn = 1'b0; prev_done = 1'b0; stable = 1'b1; cyc = 0;
      a0 = 32'h0; w0 = 32'h0; s0 = 4'h0;
      forever begin
         @(negedge clk);
         if (prev_done) begin
            check("valid_drop_after_ready", 32'(iomem_valid), 32'd0);
            prev_done = 1'b0;
         end
         if (iomem_valid) begin
            if (!in_txn) begin
               in_txn = 1'b1; cyc = 0; stable = 1'b1;
               a0 = iomem_addr; w0 = iomem_wdata; s0 = iomem_wstrb;
            end else if ((iomem_addr !== a0) || (iomem_wdata !== w0) || (iomem_wstrb !== s0)) begin
               stable = 1'b0;
            end
            cyc++;
            if (iomem_ready) begin
               in_txn = 1'b0;
               prev_done = 1'b1;
               if (bus_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL bus_unexpected: actual addr %h wstrb %h, required no bus cycle", iomem_addr, iomem_wstrb);
               end else begin
                  e = bus_q.pop_front();
                  check("bus_addr", iomem_addr, e.addr);
                  check("bus_wstrb", 32'(iomem_wstrb), 32'(e.wstrb));
                  if (e.wstrb == 4'hF) check("bus_wdata", iomem_wdata, e.wdata);
                  check("bus_valid_cycles", 32'(cyc), 32'(e.cycles));
                  check("bus_stable", 32'(stable), 32'd1);
               end
            end
         end
      end
   end

   // MISO monitor: assembles bytes sampled at SCK rising edges while selected.
   initial begin : miso_mon
      logic [7:0] sh;
      logic [7:0] exp;
      int         nb;
      sh = 8'h0; nb = 0;
      forever begin
         @(posedge spi_sck);
         if (!spi_cs_n) begin
            sh = {sh[6:0], spi_miso};
            nb++;
            if (nb == 8) begin
               nb = 0;
               if (miso_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL miso_unexpected: actual byte %h, required none", sh);
               end else begin
                  exp = miso_q.pop_front();
                  check("miso_byte", 32'(sh), 32'(exp));
               end
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         spi_mosi = b[i];
         #40;
         spi_sck = 1'b1;
         #40;
         spi_sck = 1'b0;
      end
   endtask

   task automatic frame_open();
      @(posedge clk);
      #1;
      spi_cs_n = 1'b0;
      #80;
   endtask

   task automatic frame_close();
      #40;
      spi_cs_n = 1'b1;
      for (int i = 0; (i < 2000) && iomem_valid; i++) @(posedge clk);
      check("bus_idle_after_frame", 32'(iomem_valid), 32'd0);
      repeat (30) @(posedge clk);
   endtask

   task automatic push_fill(input logic [7:0] v, input int n);
      for (int i = 0; i < n; i++) miso_q.push_back(v);
   endtask

   task automatic push_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) miso_q.push_back(w[8*i +: 8]);
   endtask

   // Reference model + driver for one complete frame. A read is on time when
   // the target answers well inside one status byte (8 SCK periods = 64 clk).
   task automatic run_frame(input logic [7:0] cmd, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] rdv, input int lat);
      bus_exp_t e;
      bit       ok;
      bus_lat  = lat;
      rd_value = rdv;
      miso_q.push_back(8'h00);
      if (cmd == 8'h02) begin
         push_fill(8'h00, 8);
         e.addr = addr; e.wdata = data; e.wstrb = 4'hF; e.cycles = (lat == 0) ? 1 : lat;
         bus_q.push_back(e);
      end else if (cmd == 8'h03) begin
         ok = (lat < 64);
         push_fill(8'h00, 4);
         miso_q.push_back(ok ? 8'h01 : 8'h00);
         push_word(ok ? rdv : 32'hFFFF_FFFF);
         e.addr = addr; e.wdata = 32'h0; e.wstrb = 4'h0; e.cycles = (lat == 0) ? 1 : lat;
         bus_q.push_back(e);
      end else begin
         push_fill(8'hFF, 8);
      end
      frame_open();
      send_byte(cmd);
      if ((cmd == 8'h02) || (cmd == 8'h03)) begin
         for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8]);
         if (cmd == 8'h02) begin
            for (int i = 3; i >= 0; i--) send_byte(data[8*i +: 8]);
         end else begin
            for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)));
         end
      end else begin
         for (int i = 0; i < 8; i++) send_byte(8'($urandom_range(0, 255)));
      end
      frame_close();
   endtask

   initial begin : watchdog
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog: actual run still active, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int          r, lat;
      logic [7:0]  cmd;
      logic [31:0] a, d, rv;

      resetn = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      resetn = 1'b1;
      @(negedge clk);
      check("reset_miso", 32'(spi_miso), 32'd1);
      check("reset_valid", 32'(iomem_valid), 32'd0);
      check("reset_wstrb", 32'(iomem_wstrb), 32'd0);
      check("reset_addr", iomem_addr, 32'h0);
      check("reset_wdata", iomem_wdata, 32'h0);
      repeat (10) @(posedge clk);

      // Write with ready held high.
      ready_hold = 1'b1;
      run_frame(8'h02, 32'h2000_0008, 32'hDEAD_BEEF, 32'h0, 0);
      ready_hold = 1'b0;
      repeat (5) @(posedge clk);

      // Read, on time.
      run_frame(8'h03, 32'h2200_0004, 32'h0, 32'h1234_5678, 2);

      // Read, late; then a normal read.
      run_frame(8'h03, 32'h2200_0004, 32'h0, 32'h1234_5678, 200);
      run_frame(8'h03, 32'h2200_0010, 32'h0, 32'hCAFE_F00D, 1);

      // Abort after two address bytes, then a write.
      push_fill(8'h00, 3);
      frame_open();
      send_byte(8'h02);
      send_byte(8'h20);
      send_byte(8'h00);
      frame_close();
      run_frame(8'h02, 32'h1000_0003, 32'h0BAD_F00D, 32'h0, 1);

      // CS rises while the write bus cycle waits 50 clk for ready.
      run_frame(8'h02, 32'h3000_0000, 32'h5555_AAAA, 32'h0, 50);
      run_frame(8'h03, 32'h3000_0001, 32'h0, 32'h8765_4321, 2);

      // Unsupported command.
      run_frame(8'h55, 32'h0, 32'h0, 32'h0, 0);

      // Randomised frames.
      for (int k = 0; k < 14; k++) begin
         r  = $urandom_range(0, 9);
         a  = $urandom;
         d  = $urandom;
         rv = $urandom;
         if (r == 0) begin
            cmd = 8'($urandom_range(4, 255));
            lat = 0;
         end else if (r <= 4) begin
            cmd = 8'h02;
            lat = $urandom_range(0, 8);
         end else begin
            cmd = 8'h03;
            lat = ($urandom_range(0, 4) == 0) ? $urandom_range(80, 250) : $urandom_range(1, 2);
         end
         run_frame(cmd, a, d, rv, lat);
      end

      repeat (20) @(posedge clk);
      check("bus_queue_empty", 32'(bus_q.size()), 32'd0);
      check("miso_queue_empty", 32'(miso_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
